uart_rx_frontend: RTL and testbench
===================================

// Module: uart_rx_frontend
// PURPOSE
//  Receive front end that sits directly upstream of the UART byte receiver.
//  Synchronises the raw RX pin into the clk domain and drives rx_sync_out.
//  Detects a start edge and generates the single-cycle center_tick strobes.
//  Ticks land mid-bit for the start bit, FRAME_BITS data bits and the stop bit.
//  The receiver samples rx_sync_out on these ticks.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  system clock frequency
//  BAUD         115200       line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer divide)
//  FRAME_BITS   8            data bits per frame; must match the downstream receiver
//  SYNC_STAGES  2            flip-flops in the input synchroniser, >=2
//  Derived:     HALF_BIT = CLKS_PER_BIT/2
//  Elaboration error if CLKS_PER_BIT < 4.
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  rx_async_in  in   1  raw RX pin, asynchronous, idles high
//  rx_sync_out  out  1  synchronised RX level, to the receiver
//  center_tick  out  1  one-cycle strobe at each bit centre, to the receiver
//  busy         out  1  high while a frame is being timed (state != IDLE)
// BEHAVIOUR
//  Clocking and reset
//   - One clock; every register is updated only on the rising edge of clk.
//   - Reset (synchronous): all synchroniser flops = 1, previous-sample flop = 1.
//   - Reset values: rx_sync_out = 1, center_tick = 0, busy = 0.
//   - Reset values: state = IDLE, bit_cnt = 0, tick_cnt = 0.
//   - Reset asserted mid-frame aborts the frame immediately; there are no further ticks.
//  Synchroniser
//   - rx_sync_out = last synchroniser stage.
//   - Latency from rx_async_in to rx_sync_out is SYNC_STAGES cycles.
//   - prev = rx_sync_out delayed by one cycle.
//   - fall = prev & ~rx_sync_out.
//  State machine (all outputs registered)
//   IDLE
//    - On fall: bit_cnt <= 0, tick_cnt <= 0, go to HALF.
//    - A line held low does not retrigger; a new 1->0 edge is required.
//   HALF
//    - bit_cnt increments each cycle.
//    - When bit_cnt == HALF_BIT-1: center_tick = 1 for one cycle, bit_cnt <= 0.
//    - The first tick occurs HALF_BIT cycles after the cycle fall was seen.
//    - If rx_sync_out == 1 on that cycle (false start): go to IDLE; this tick is still emitted.
//    - Otherwise: tick_cnt <= 1, go to RUN.
//   RUN
//    - bit_cnt increments each cycle.
//    - When bit_cnt == CLKS_PER_BIT-1: center_tick = 1, bit_cnt <= 0, tick_cnt++.
//    - When the tick making tick_cnt == FRAME_BITS+2 fires (the stop-bit tick): go to IDLE.
//   Ticks and timing
//    - Ticks per good frame = FRAME_BITS+2; spacing after the first tick is exactly CLKS_PER_BIT.
//    - The stop bit is not checked here; that is the receiver's job.
//    - IDLE is re-entered mid-stop-bit, so a back-to-back start edge is caught.
//   Other rules
//    - busy = (state != IDLE), registered alongside state.
//    - center_tick is never high for two consecutive cycles.
//    - Illegal state encoding -> IDLE.
// TESTING (CLK_FREQ_HZ=16, BAUD=1 -> CLKS_PER_BIT=16, HALF_BIT=8; FRAME_BITS=8)
//  1. Reset for 3 cycles with rx_async_in = 0
//     -> rx_sync_out = 1, center_tick = 0, busy = 0 during reset.
//     -> After release: rx_sync_out falls 2 cycles later and busy rises on a fall.
//  2. Send frame 0x55 (start, LSB first, stop), 16 clk/bit
//     -> Exactly 10 ticks: first 8 cycles after fall, then every 16 cycles.
//     -> Sampled levels are 0,1,0,1,0,1,0,1,0,1; busy drops after the 10th tick.
//  3. Glitch: rx_async_in low for 3 cycles, then high
//     -> One tick (rx_sync_out = 1 at tick), busy = 0 the next cycle, no further ticks for 200 cycles.
//  4. Break: line held low for 400 cycles after a frame start
//     -> Exactly 10 ticks, then IDLE with no retrigger.
//     -> A new frame after the line returns high is timed normally.
//  5. Assert reset at the 5th tick of a frame
//     -> No ticks while in reset or afterwards until a new fall; busy = 0 the cycle after reset.
//  6. Back-to-back frames 0xA3 then 0x0F with 1-bit stop
//     -> 20 ticks total, all 16 apart within each frame.
//     -> The second frame's first tick is 8 cycles after its start edge.
//     -> The downstream receiver yields 0xA3 then 0x0F.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// UART receive front end: synchronises the RX pin, detects a start edge and
// strobes center_tick at the middle of the start, data and stop bits.
module uart_rx_frontend #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int FRAME_BITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_async_in,
    output logic rx_sync_out,
    output logic center_tick,
    output logic busy
);

    localparam int CLKS_PER_BIT    = CLK_FREQ_HZ / BAUD;
    localparam int HALF_BIT        = CLKS_PER_BIT / 2;
    localparam int TICKS_PER_FRAME = FRAME_BITS + 2;
    localparam int CNT_W           = $clog2(CLKS_PER_BIT);
    localparam int TICK_W          = $clog2(TICKS_PER_FRAME + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_PRE  = CNT_W'(HALF_BIT - 2);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [TICK_W-1:0] STOP_CNT = TICK_W'(TICKS_PER_FRAME - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx_frontend: CLKS_PER_BIT must be at least 4");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("uart_rx_frontend: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HALF = 2'b01,
        RUN  = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   fall;

    state_t             state, state_next;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_next;
    logic [TICK_W-1:0]  tick_cnt, tick_cnt_next;
    logic               tick_next;
    logic               busy_next;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_sync_out = sync_q[SYNC_STAGES-1];
    assign fall        = prev_q & ~rx_sync_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tick_cnt    <= '0;
            center_tick <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            tick_cnt    <= tick_cnt_next;
            center_tick <= tick_next;
            busy        <= busy_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        tick_cnt_next = tick_cnt;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_next    = HALF;
                    bit_cnt_next  = '0;
                    tick_cnt_next = '0;
                end
            end
            HALF: begin
                if (bit_cnt == HALF_LAST) begin
                    bit_cnt_next = '0;
                    if (rx_sync_out) begin
                        state_next = IDLE;
                    end else begin
                        tick_cnt_next = TICK_W'(1);
                        state_next    = RUN;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_next  = '0;
                    tick_cnt_next = tick_cnt + TICK_W'(1);
                    if (tick_cnt == STOP_CNT) begin
                        state_next = IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                bit_cnt_next  = '0;
                tick_cnt_next = '0;
            end
        endcase
    end

    // Decoded one count early so the registered strobe lands on the cycle
    // the counter reaches its terminal value.
    always_comb begin
        tick_next = 1'b0;
        case (state)
            HALF:    tick_next = (bit_cnt == HALF_PRE);
            RUN:     tick_next = (bit_cnt == BIT_PRE);
            default: tick_next = 1'b0;
        endcase
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: directed scenarios plus random
// frames, each cycle compared against an event-timed reference model.
module tb_uart_rx_frontend;

    localparam int CPB = 16;
    localparam int FB  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_async_in = 1'b0;
    logic rx_sync_out, center_tick, busy;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc_n = 0;
    int n_ticks = 0;
    logic samples[$];
    int   tick_times[$];
    int   last_start = 0;

    // Reference model state: line history and expected tick schedule.
    logic m_rx_d1 = 1'b1;
    logic m_rst_d1 = 1'b1;
    logic m_sync_prev = 1'b1;
    bit   m_active = 1'b0;
    int   m_next = 0;
    int   m_k = 0;

    uart_rx_frontend #(
        .CLK_FREQ_HZ(16),
        .BAUD(1),
        .FRAME_BITS(FB),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_async_in(rx_async_in),
        .rx_sync_out(rx_sync_out),
        .center_tick(center_tick),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare outputs mid-cycle.
    task automatic step(input logic rx_v, input logic rst_v);
        logic exp_sync, exp_tick, exp_busy, m_fall;
        rx_async_in = rx_v;
        reset       = rst_v;
        @(posedge clk);
        cyc_n++;
        exp_sync = (rst_v || m_rst_d1) ? 1'b1 : m_rx_d1;
        m_fall   = m_sync_prev & ~exp_sync;
        exp_tick = 1'b0;
        exp_busy = 1'b0;
        if (rst_v) begin
            m_active = 1'b0;
        end else if (m_active) begin
            exp_busy = 1'b1;
            if (cyc_n == m_next) begin
                exp_tick = 1'b1;
                if (m_k == 0 && exp_sync) begin
                    m_active = 1'b0;
                end else begin
                    m_k++;
                    if (m_k == FB + 2) m_active = 1'b0;
                    else m_next = cyc_n + CPB;
                end
            end
        end else if (m_fall) begin
            m_active = 1'b1;
            m_k      = 0;
            m_next   = cyc_n + CPB / 2;
        end
        m_rx_d1     = rx_v;
        m_rst_d1    = rst_v;
        m_sync_prev = exp_sync;
        @(negedge clk);
        check("rx_sync_out", {31'd0, rx_sync_out}, {31'd0, exp_sync});
        check("center_tick", {31'd0, center_tick}, {31'd0, exp_tick});
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
        if (center_tick) begin
            n_ticks++;
            samples.push_back(rx_sync_out);
            tick_times.push_back(cyc_n);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl, 1'b0);
    endtask

    task automatic clear_obs();
        n_ticks = 0;
        samples.delete();
        tick_times.delete();
    endtask

    // Sends start, LSB-first data and stop bits; optionally pulses reset for
    // two cycles right after the rst_tick-th observed tick.
    task automatic send_frame(input logic [7:0] data, input int stop_bits, input int rst_tick);
        logic [10:0] fr;
        int rst_left;
        bit fired;
        fr = {2'b11, data, 1'b0};
        rst_left = 0;
        fired = 1'b0;
        last_start = cyc_n + 1;
        for (int i = 0; i < (9 + stop_bits) * CPB; i++) begin
            if (rst_tick != 0 && !fired && n_ticks == rst_tick) begin
                fired = 1'b1;
                rst_left = 2;
            end
            step(fr[(i / CPB > 10) ? 10 : i / CPB], rst_left > 0);
            if (rst_left > 0) rst_left--;
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp_byte, input int base);
        logic [7:0] got;
        if (samples.size() >= base + 10) begin
            got = '0;
            for (int b = 0; b < 8; b++) got[b] = samples[base + 1 + b];
            check({tag, "_start"}, {31'd0, samples[base]}, 32'd0);
            check({tag, "_byte"}, {24'd0, got}, {24'd0, exp_byte});
            check({tag, "_stop"}, {31'd0, samples[base + 9]}, 32'd1);
        end else begin
            check({tag, "_nsamples"}, samples.size(), base + 10);
        end
    endtask

    task automatic check_spacing(input string tag, input int first, input int last);
        if (tick_times.size() > last) begin
            for (int i = first + 1; i <= last; i++)
                check(tag, tick_times[i] - tick_times[i - 1], CPB);
        end else begin
            check({tag, "_ntimes"}, tick_times.size(), last + 1);
        end
    endtask

    initial begin
        logic [7:0] rb;
        int s1, s2;

        // 1: reset with the line low, then release into a held-low line.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check("rst_sync", {31'd0, rx_sync_out}, 32'd1);
        check("rst_tick", {31'd0, center_tick}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        clear_obs();
        step(1'b0, 1'b0);
        check("rel_sync_c1", {31'd0, rx_sync_out}, 32'd1);
        step(1'b0, 1'b0);
        check("rel_sync_c2", {31'd0, rx_sync_out}, 32'd0);
        step(1'b0, 1'b0);
        check("rel_busy", {31'd0, busy}, 32'd1);
        hold(1'b0, 200);
        check("rel_ticks", n_ticks, 10);
        hold(1'b1, 40);

        // 2: frame 0x55, one stop bit.
        clear_obs();
        send_frame(8'h55, 1, 0);
        hold(1'b1, 20);
        check("f55_ticks", n_ticks, 10);
        check_frame("f55", 8'h55, 0);
        if (tick_times.size() > 0) check("f55_first", tick_times[0] - (last_start + 1), CPB / 2);
        check_spacing("f55_space", 0, 9);
        check("f55_busy_end", {31'd0, busy}, 32'd0);

        // 3: three-cycle glitch is a false start.
        clear_obs();
        hold(1'b0, 3);
        hold(1'b1, 200);
        check("glitch_ticks", n_ticks, 1);
        if (samples.size() > 0) check("glitch_level", {31'd0, samples[0]}, 32'd1);

        // 4: break, then a normal frame.
        clear_obs();
        hold(1'b0, 400);
        check("break_ticks", n_ticks, 10);
        hold(1'b1, 40);
        clear_obs();
        send_frame(8'h3C, 1, 0);
        hold(1'b1, 20);
        check("after_break_ticks", n_ticks, 10);
        check_frame("after_break", 8'h3C, 0);

        // 5: reset at the 5th tick of a frame.
        clear_obs();
        send_frame(8'hFF, 1, 5);
        hold(1'b1, 40);
        check("rst_mid_ticks", n_ticks, 5);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);

        // 6: back-to-back frames.
        clear_obs();
        send_frame(8'hA3, 1, 0);
        s1 = last_start;
        send_frame(8'h0F, 1, 0);
        s2 = last_start;
        hold(1'b1, 20);
        check("b2b_ticks", n_ticks, 20);
        check_frame("b2b_a3", 8'hA3, 0);
        check_frame("b2b_0f", 8'h0F, 10);
        if (tick_times.size() >= 20) begin
            check("b2b_first1", tick_times[0] - (s1 + 1), CPB / 2);
            check("b2b_first2", tick_times[10] - (s2 + 1), CPB / 2);
        end
        check_spacing("b2b_space1", 0, 9);
        check_spacing("b2b_space2", 10, 19);

        // Random frames with random gaps, stop lengths and occasional glitches.
        for (int f = 0; f < 12; f++) begin
            hold(1'b1, $urandom_range(0, 30));
            if ($urandom_range(0, 3) == 0) begin
                hold(1'b0, $urandom_range(1, 5));
                hold(1'b1, 20);
            end
            rb = 8'($urandom_range(0, 255));
            clear_obs();
            send_frame(rb, $urandom_range(1, 2), 0);
            check("rnd_ticks", n_ticks, 10);
            check_frame("rnd", rb, 0);
        end
        hold(1'b1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
